fc_layer_seq: RTL and testbench
===============================

Name: fc_layer_seq

Overview:
- Parametrised controller for one fully-connected NN layer.
- Sequences weight/data RAM reads for NEU_NUM neurons × IN_NUM inputs, counts MAC completions, and runs a bias/activation handshake per neuron.
- Gathers activated results into an indexed result vector; presents it to the next layer through a valid/ready handshake.
- Sits between the layer start logic, the shared weight/data SRAMs, the MAC/bias/activation datapath and the next-layer controller.

Parameters:
- DATA_W, 8, activation/result width.
- IN_NUM, 26, inputs (MAC steps) per neuron; ≥2.
- NEU_NUM, 16, neurons per layer; ≥2.
- PACK, 2, activations packed per data-RAM word; power of 2.
- WADDR_W, 9, weight address width.
- DADDR_W, 5, data address width; ≥ clog2(ceil(IN_NUM/PACK)).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  layer job request
- in_ready  out  1  job accepted (high in IDLE)
- cfg_w_base  in  WADDR_W  weight base address, sampled on accept
- mac_ready  in  1  MAC can take a new operand pair
- weight_addr  out  WADDR_W  weight RAM address
- data_addr  out  DADDR_W  data RAM word address
- data_sel  out  clog2(PACK)  activation lane within data word, aligned to data_valid
- rd_en  out  1  RAM read strobe
- data_valid  out  1  rd_en delayed 1 cycle (RAM operands valid)
- mac_ack  in  1  one MAC accumulation completed
- bias_valid  out  1  neuron accumulation complete, request bias+activation
- bias_ready  in  1  activation result valid on act_result this cycle
- bias_sel  out  clog2(NEU_NUM)  current neuron index
- act_result  in  DATA_W  activated neuron output
- out_valid  out  1  result vector complete
- out_ready  in  1  next layer accepts vector
- result_bus  out  NEU_NUM*DATA_W  neuron i at [i*DATA_W +: DATA_W]
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all counters 0; rd_en, data_valid, bias_valid, out_valid, busy = 0; result_bus = 0; weight_addr = 0; data_sel = 0.
- States: IDLE, ISSUE, WAIT_MAC, BIAS, DONE.
- IDLE: in_ready = 1. On in_valid, latch cfg_w_base, clear result_bus, neu = 0, k = 0 → ISSUE.
- ISSUE:
  - rd_en = mac_ready.
  - weight_addr = base + neu*IN_NUM + k, computed modulo 2^WADDR_W; wrap is silent.
  - data_addr = k / PACK; lane = k % PACK.
  - k increments only on a cycle with rd_en = 1.
  - After issuing k = IN_NUM-1 → WAIT_MAC.
  - mac_ready low stalls address generation with no skip and no repeat.
- data_valid and data_sel are rd_en and the lane delayed exactly 1 cycle. A read issued on the last ISSUE cycle still yields data_valid in WAIT_MAC.
- mac_cnt counts mac_ack in ISSUE/WAIT_MAC. When mac_cnt reaches IN_NUM → BIAS and mac_cnt clears. mac_ack while in BIAS/DONE/IDLE is ignored.
- BIAS:
  - bias_valid = 1 (level, registered state decode).
  - bias_sel = neu.
  - On bias_ready, write act_result into slot neu.
  - If neu == NEU_NUM-1 → DONE; else neu++, k = 0 → ISSUE.
  - bias_ready outside BIAS is ignored.
- DONE: out_valid = 1; result_bus stable. On out_ready → IDLE. in_valid is not accepted until IDLE.
- Simultaneous mac_ack on the cycle ISSUE→WAIT_MAC is counted.
- rst_n low mid-job aborts immediately to the reset values. No partial result is retained.
- Counter widths: k, mac_cnt clog2(IN_NUM+1); neu clog2(NEU_NUM).

Decomposition:
- Shared package fc_pkg: state encoding (one-hot localparams IDLE/ISSUE/WAIT_MAC/BIAS/DONE) and the clog2-derived width constants; reused by the L2/L3 controllers.
- One natural sub-module: fc_addr_gen. It owns k, neu*IN_NUM accumulation (running add, no multiplier), weight_addr, data_addr, lane, and the 1-cycle rd_en/data_sel delay.

Test Plan:
- Nominal: IN_NUM=26, NEU_NUM=16, PACK=2, base=27, mac_ready=1, MAC acks 2 cycles after each data_valid, bias_ready 3 cycles after bias_valid returning 8'h10+i → weight_addr runs 27..442 contiguously; data_addr 0..12 per neuron with data_sel 0,1 alternating; 16 bias_valid episodes; result_bus slot i = 8'h10+i; out_valid high until out_ready.
- Backpressure: mac_ready toggled pseudo-randomly → exactly IN_NUM rd_en pulses per neuron; no address skipped or duplicated; data_valid count = rd_en count.
- Wrap: base=9'h1F0, IN_NUM=26 → weight_addr wraps 9'h1FF→9'h000 without error; totals unchanged.
- Stray handshakes: mac_ack during BIAS, bias_ready during ISSUE → ignored; counts and results unaffected.
- Output hold: out_ready held low 50 cycles in DONE, in_valid high → stays DONE, result_bus stable, in_ready=0; out_ready pulse → IDLE next cycle, new job accepted and result_bus cleared.
- Reset mid-job: assert rst_n low during neuron 7 ISSUE → all outputs at reset values asynchronously; new job after release restarts at neu=0, k=0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer controllers: one-hot state
// encoding and width helpers for counters and index buses.
package fc_pkg;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        ISSUE    = 5'b00010,
        WAIT_MAC = 5'b00100,
        BIAS     = 5'b01000,
        DONE     = 5'b10000
    } state_t;

    // Counter able to hold the value n itself
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Index into n items, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_addr_gen.sv
// Weight/data RAM address generator for one layer: steps k per granted read
// and advances the neuron weight offset with a running add.
module fc_addr_gen
    import fc_pkg::*;
#(
    parameter int unsigned IN_NUM  = 26,
    parameter int unsigned PACK    = 2,
    parameter int unsigned WADDR_W = 9,
    parameter int unsigned DADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     next_neu,
    input  logic                     issue_en,
    input  logic                     mac_ready,
    input  logic [WADDR_W-1:0]       cfg_w_base,
    output logic [WADDR_W-1:0]       weight_addr,
    output logic [DADDR_W-1:0]       data_addr,
    output logic [idx_w(PACK)-1:0]   data_sel,
    output logic                     rd_en,
    output logic                     data_valid,
    output logic                     last_c
);

    localparam int unsigned K_W = cnt_w(IN_NUM);
    localparam int unsigned L_W = idx_w(PACK);
    localparam logic [K_W-1:0] K_LAST = K_W'(IN_NUM - 1);
    localparam logic [WADDR_W-1:0] NEU_STEP = WADDR_W'(IN_NUM);

    logic [K_W-1:0]     k;
    logic [WADDR_W-1:0] base;
    logic [WADDR_W-1:0] neu_off;
    logic [L_W-1:0]     lane;

    // A read goes out only when the MAC can take the operand pair
    assign rd_en       = issue_en & mac_ready;
    assign last_c      = rd_en && (k == K_LAST);
    assign weight_addr = base + neu_off + WADDR_W'(k);
    assign data_addr   = DADDR_W'(k >> L_W);
    assign lane        = k[L_W-1:0];

    // Step counters and delay the read strobe/lane to the RAM output cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k          <= '0;
            base       <= '0;
            neu_off    <= '0;
            data_valid <= 1'b0;
            data_sel   <= '0;
        end else begin
            data_valid <= rd_en;
            data_sel   <= lane;
            if (start) begin
                base    <= cfg_w_base;
                neu_off <= '0;
                k       <= '0;
            end else if (next_neu) begin
                neu_off <= neu_off + NEU_STEP;
                k       <= '0;
            end else if (rd_en) begin
                k <= k + K_W'(1);
            end
        end
    end

endmodule

// File: rtl/fc_layer_seq.sv
// Fully-connected layer sequencer: issues operand reads, counts MAC
// completions, runs the per-neuron bias/activation handshake and hands the
// gathered result vector to the next layer.
module fc_layer_seq
    import fc_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned IN_NUM  = 26,
    parameter int unsigned NEU_NUM = 16,
    parameter int unsigned PACK    = 2,
    parameter int unsigned WADDR_W = 9,
    parameter int unsigned DADDR_W = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WADDR_W-1:0]          cfg_w_base,
    input  logic                        mac_ready,
    output logic [WADDR_W-1:0]          weight_addr,
    output logic [DADDR_W-1:0]          data_addr,
    output logic [idx_w(PACK)-1:0]      data_sel,
    output logic                        rd_en,
    output logic                        data_valid,
    input  logic                        mac_ack,
    output logic                        bias_valid,
    input  logic                        bias_ready,
    output logic [idx_w(NEU_NUM)-1:0]   bias_sel,
    input  logic [DATA_W-1:0]           act_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NEU_NUM*DATA_W-1:0]   result_bus,
    output logic                        busy
);

    localparam int unsigned K_W = cnt_w(IN_NUM);
    localparam int unsigned N_W = idx_w(NEU_NUM);
    localparam logic [K_W-1:0] MAC_LAST = K_W'(IN_NUM - 1);
    localparam logic [K_W-1:0] MAC_FULL = K_W'(IN_NUM);
    localparam logic [N_W-1:0] NEU_LAST = N_W'(NEU_NUM - 1);

    state_t         state;
    state_t         state_nxt;
    logic [K_W-1:0] mac_cnt;
    logic [N_W-1:0] neu;
    logic           start_c;
    logic           next_neu_c;
    logic           capture_c;
    logic           issue_last_c;
    logic           mac_cnt_en_c;
    logic           mac_done_c;

    fc_addr_gen #(
        .IN_NUM  (IN_NUM),
        .PACK    (PACK),
        .WADDR_W (WADDR_W),
        .DADDR_W (DADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_c),
        .next_neu    (next_neu_c),
        .issue_en    (state == ISSUE),
        .mac_ready   (mac_ready),
        .cfg_w_base  (cfg_w_base),
        .weight_addr (weight_addr),
        .data_addr   (data_addr),
        .data_sel    (data_sel),
        .rd_en       (rd_en),
        .data_valid  (data_valid),
        .last_c      (issue_last_c)
    );

    // Acks only count while this neuron's reads or their results are in flight
    assign mac_cnt_en_c = mac_ack && ((state == ISSUE) || (state == WAIT_MAC));
    assign mac_done_c   = (state == WAIT_MAC) &&
                          ((mac_cnt == MAC_FULL) || (mac_ack && (mac_cnt == MAC_LAST)));

    assign in_ready   = (state == IDLE);
    assign busy       = (state != IDLE);
    assign bias_valid = (state == BIAS);
    assign out_valid  = (state == DONE);
    assign bias_sel   = neu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_c    = 1'b0;
        next_neu_c = 1'b0;
        capture_c  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    start_c   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_last_c) begin
                    state_nxt = WAIT_MAC;
                end
            end
            WAIT_MAC: begin
                if (mac_done_c) begin
                    state_nxt = BIAS;
                end
            end
            BIAS: begin
                if (bias_ready) begin
                    capture_c = 1'b1;
                    if (neu == NEU_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        next_neu_c = 1'b1;
                        state_nxt  = ISSUE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_cnt <= '0;
        end else if (start_c || mac_done_c) begin
            mac_cnt <= '0;
        end else if (mac_cnt_en_c && (mac_cnt != MAC_FULL)) begin
            mac_cnt <= mac_cnt + K_W'(1);
        end
    end

    // Neuron index and result gathering; a new job starts from an empty vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neu        <= '0;
            result_bus <= '0;
        end else if (start_c) begin
            neu        <= '0;
            result_bus <= '0;
        end else begin
            if (capture_c) begin
                result_bus[int'(neu) * DATA_W +: DATA_W] <= act_result;
            end
            if (next_neu_c) begin
                neu <= neu + N_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Self-checking bench for fc_layer_seq: MAC/bias responders, a per-cycle
// checker against the expected read stream and result vector, directed jobs.
module tb_fc_layer_seq;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned IN_NUM  = 26;
    localparam int unsigned NEU_NUM = 16;
    localparam int unsigned PACK    = 2;
    localparam int unsigned WADDR_W = 9;
    localparam int unsigned DADDR_W = 5;
    localparam int unsigned TOTAL   = IN_NUM * NEU_NUM;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [WADDR_W-1:0]        cfg_w_base = '0;
    logic                      mac_ready = 1'b0;
    logic [WADDR_W-1:0]        weight_addr;
    logic [DADDR_W-1:0]        data_addr;
    logic [0:0]                data_sel;
    logic                      rd_en;
    logic                      data_valid;
    logic                      mac_ack = 1'b0;
    logic                      bias_valid;
    logic                      bias_ready = 1'b0;
    logic [3:0]                bias_sel;
    logic [DATA_W-1:0]         act_result = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [NEU_NUM*DATA_W-1:0] result_bus;
    logic                      busy;

    fc_layer_seq #(
        .DATA_W(DATA_W), .IN_NUM(IN_NUM), .NEU_NUM(NEU_NUM),
        .PACK(PACK), .WADDR_W(WADDR_W), .DADDR_W(DADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_w_base(cfg_w_base), .mac_ready(mac_ready), .weight_addr(weight_addr),
        .data_addr(data_addr), .data_sel(data_sel), .rd_en(rd_en),
        .data_valid(data_valid), .mac_ack(mac_ack), .bias_valid(bias_valid),
        .bias_ready(bias_ready), .bias_sel(bias_sel), .act_result(act_result),
        .out_valid(out_valid), .out_ready(out_ready), .result_bus(result_bus),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    // Responder / job controls
    logic       bp_en = 1'b0;
    logic       stray_en = 1'b0;
    logic [7:0] act_off = 8'h00;
    logic       mac_gen = 1'b0;

    // Checker state
    logic [WADDR_W-1:0] cur_base = '0;
    logic [7:0]         cur_off = 8'h00;
    logic [WADDR_W-1:0] last_waddr = '0;
    logic [WADDR_W-1:0] first_waddr = '0;
    int rd_idx = 0;
    int dv_idx = 0;
    int ep = 0;
    int ack_cnt = 0;
    logic prev_bv = 1'b0;
    logic prev_ov = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] exp_bus(input logic [7:0] off);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < int'(NEU_NUM); i++) begin
            b[i*DATA_W +: DATA_W] = 8'(8'h10 + i + off);
        end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MAC returns an ack 2 cycles after each data_valid; bias answers 3 cycles
    // after bias_valid rises; optional stray handshakes outside their states.
    initial begin
        logic [1:0] ackq;
        int bcnt;
        ackq = '0;
        bcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            mac_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            mac_gen   = ackq[1];
            mac_ack   = ackq[1] | (stray_en & bias_valid);
            ackq[1]   = ackq[0];
            ackq[0]   = data_valid;
            if (bias_ready) begin
                bias_ready = 1'b0;
                act_result = 8'h00;
            end else if (bias_valid) begin
                bcnt++;
                if (bcnt == 4) begin
                    bias_ready = 1'b1;
                    act_result = 8'(8'h10 + bias_sel + act_off);
                    bcnt = 0;
                end
            end else begin
                bcnt = 0;
                if (stray_en && busy && !out_valid && ($urandom_range(0, 3) == 0)) begin
                    bias_ready = 1'b1;
                    act_result = 8'hEE;
                end
            end
        end
    end

    // Per-cycle checker against the expected read stream and result vector
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_bv = 1'b0;
                prev_ov = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    cur_base = cfg_w_base;
                    cur_off  = act_off;
                    rd_idx = 0;
                    dv_idx = 0;
                    ep = 0;
                    ack_cnt = 0;
                end
                if (mac_gen) ack_cnt++;
                if (rd_en) begin
                    if (rd_idx >= int'(TOTAL)) begin
                        chk("rd_count", rd_idx + 1, TOTAL);
                    end else begin
                        chk("weight_addr", weight_addr, 9'(cur_base + rd_idx));
                        chk("data_addr", data_addr, (rd_idx % IN_NUM) / PACK);
                        if (rd_idx == 0) first_waddr = weight_addr;
                        last_waddr = weight_addr;
                        rd_idx++;
                    end
                end
                if (data_valid) begin
                    chk("data_sel", data_sel, (dv_idx % IN_NUM) % PACK);
                    dv_idx++;
                end
                if (bias_valid && !prev_bv) begin
                    chk("bias_sel", bias_sel, ep);
                    chk("rd_per_neuron", rd_idx, (ep + 1) * IN_NUM);
                    chk("dv_per_neuron", dv_idx, (ep + 1) * IN_NUM);
                    chk("acks_before_bias", ack_cnt, (ep + 1) * IN_NUM);
                    ep++;
                end
                if (out_valid) begin
                    chk("result_bus", result_bus, exp_bus(cur_off));
                    chk("in_ready_done", in_ready, 0);
                    if (!prev_ov) begin
                        chk("episodes", ep, NEU_NUM);
                        chk("rd_total", rd_idx, TOTAL);
                        chk("dv_total", dv_idx, TOTAL);
                    end
                end
                prev_bv = bias_valid;
                prev_ov = out_valid;
            end
        end
    end

    task automatic wait_out(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 5000) begin
            tick();
            n++;
        end
        chk(name, out_valid, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_data_valid"}, data_valid, 0);
        chk({tag, "_bias_valid"}, bias_valid, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_result_bus"}, result_bus, 0);
        chk({tag, "_weight_addr"}, weight_addr, 0);
        chk({tag, "_data_sel"}, data_sel, 0);
        chk({tag, "_bias_sel"}, bias_sel, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        check_reset_vals("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Job 1: nominal, base 27
        cfg_w_base = 9'd27;
        act_off = 8'h00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out("job1_done");
        chk("job1_first_waddr", first_waddr, 9'd27);
        chk("job1_last_waddr", last_waddr, 9'd442);
        chk("job1_slot0", result_bus[7:0], 8'h10);
        chk("job1_slot15", result_bus[127:120], 8'h1F);

        // Output hold with next job already requested (wrap + backpressure + strays)
        cfg_w_base = 9'h1F0;
        act_off = 8'h20;
        bp_en = 1'b1;
        stray_en = 1'b1;
        in_valid = 1'b1;
        repeat (50) tick();
        chk("hold_out_valid", out_valid, 1);
        chk("hold_busy", busy, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("job2_busy", busy, 1);
        chk("job2_cleared", result_bus, 0);
        wait_out("job2_done");
        chk("job2_first_waddr", first_waddr, 9'h1F0);
        chk("job2_last_waddr", last_waddr, 9'd399);
        chk("job2_slot0", result_bus[7:0], 8'h30);
        chk("job2_slot15", result_bus[127:120], 8'h3F);
        bp_en = 1'b0;
        stray_en = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Job 3: aborted by reset during neuron 7 ISSUE
        cfg_w_base = 9'd100;
        act_off = 8'h40;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!(bias_sel == 4'd7 && rd_en) && n < 5000) begin
            tick();
            n++;
        end
        chk("job3_reach_neu7", bias_sel, 7);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("after_abort_busy", busy, 0);

        // Job 4: restart from neuron 0, k 0
        cfg_w_base = 9'd5;
        act_off = 8'h50;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out("job4_done");
        chk("job4_first_waddr", first_waddr, 9'd5);
        chk("job4_last_waddr", last_waddr, 9'd420);
        chk("job4_slot7", result_bus[63:56], 8'h67);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("job4_idle", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
